// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand flag bits, result flag layout, biases, default NaN.
package fpu_pkg;

    // Operand flag bit positions (fla/flb)
    localparam int unsigned FL_ZERO = 3;
    localparam int unsigned FL_INF  = 2;
    localparam int unsigned FL_NAN  = 1;
    localparam int unsigned FL_SNAN = 0;

    // Result flag layout: {ZEROq, INFq, NANq, INV, DBZ, nanq[52:0]}
    localparam int unsigned FLQ_ZERO = 57;
    localparam int unsigned FLQ_INF  = 56;
    localparam int unsigned FLQ_NAN  = 55;
    localparam int unsigned FLQ_INV  = 54;
    localparam int unsigned FLQ_DBZ  = 53;

    localparam logic [12:0] BIAS_D   = 13'd1023;
    localparam logic [12:0] BIAS_S   = 13'd127;
    localparam logic [52:0] QNAN_DEF = 53'h18000000000000;

    // One quotient bit per weight 2^0 .. 2^-54
    localparam int unsigned DIV_ITERS = 55;

    // Unrounded significand: [56] 2^1 .. [1] 2^-54, [0] sticky
    typedef logic [56:0] usig_t;

    typedef enum logic [1:0] {StIdle, StMul, StDiv, StDivOut} md_state_t;

endpackage

// File: rtl/mul_div_special.sv
// Combinational special-value / exception decoder for multiply and divide.
module mul_div_special
    import fpu_pkg::*;
(
    input  logic        fdiv,
    input  logic [3:0]  fla,
    input  logic [3:0]  flb,
    input  logic [52:0] nan,
    output logic [57:0] flq
);

    logic a_nan, b_nan, a_zero, b_zero, a_inf, b_inf;
    logic zq, iq, nq, inv, dbz;
    logic [52:0] sig;

    assign a_nan  = fla[FL_NAN] | fla[FL_SNAN];
    assign b_nan  = flb[FL_NAN] | flb[FL_SNAN];
    assign a_zero = fla[FL_ZERO];
    assign b_zero = flb[FL_ZERO];
    assign a_inf  = fla[FL_INF];
    assign b_inf  = flb[FL_INF];

    // Priority: NaN propagation, then invalid, then infinity, then zero
    always_comb begin
        zq  = 1'b0;
        iq  = 1'b0;
        nq  = 1'b0;
        inv = 1'b0;
        dbz = 1'b0;
        sig = '0;
        if (a_nan || b_nan) begin
            nq  = 1'b1;
            inv = fla[FL_SNAN] | flb[FL_SNAN];
            sig = nan;
        end else if (!fdiv) begin
            if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                nq  = 1'b1;
                inv = 1'b1;
                sig = QNAN_DEF;
            end else if (a_inf || b_inf) begin
                iq = 1'b1;
            end else if (a_zero || b_zero) begin
                zq = 1'b1;
            end
        end else begin
            if ((a_zero && b_zero) || (a_inf && b_inf)) begin
                nq  = 1'b1;
                inv = 1'b1;
                sig = QNAN_DEF;
            end else if (a_inf) begin
                iq = 1'b1;
            end else if (b_zero) begin
                // a is finite and nonzero here
                iq  = 1'b1;
                dbz = 1'b1;
            end else if (b_inf || a_zero) begin
                zq = 1'b1;
            end
        end
        flq = {zq, iq, nq, inv, dbz, sig};
    end

endmodule

// File: rtl/mul_div.sv
// Significand/exponent core for FP multiply (2 cycles) and radix-2 restoring divide.
module mul_div
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        fdiv,
    input  logic        db,
    input  logic        sa,
    input  logic        sb,
    input  logic [52:0] fa,
    input  logic [52:0] fb,
    input  logic [10:0] ea,
    input  logic [10:0] eb,
    input  logic [5:0]  lza,
    input  logic [5:0]  lzb,
    input  logic [52:0] nan,
    input  logic [3:0]  fla,
    input  logic [3:0]  flb,
    output logic [56:0] fq,
    output logic [12:0] eq,
    output logic        sq,
    output logic [57:0] flq
);

    md_state_t   state_q;
    logic        busy_q, done_q, mul_fin_q;
    logic        fdiv_q, sign_q;
    logic [52:0] fa_q, fb_q, nan_q;
    logic [3:0]  fla_q, flb_q;
    logic [12:0] exp_q;
    logic [105:0] prod_q;
    logic [53:0] rem_q;
    logic [54:0] quo_q;
    logic [5:0]  cnt_q;
    usig_t       fq_q;
    logic [12:0] eq_q;
    logic        sq_q;
    logic [57:0] flq_q;

    logic [12:0] ea_x, eb_x, bias, ta, tb, exp_d;
    logic [105:0] prod;
    logic        qbit;
    logic [53:0] rem_sub, rem_nxt;
    logic [57:0] spec_flq;
    logic        spec_any;
    usig_t       res_fq;
    logic [12:0] res_eq;

    // Result exponent from the raw inputs, captured at accept
    always_comb begin
        ea_x  = db ? {2'b00, ea} : {5'b0, ea[7:0]};
        eb_x  = db ? {2'b00, eb} : {5'b0, eb[7:0]};
        bias  = db ? BIAS_D : BIAS_S;
        ta    = ea_x - {7'b0, lza};
        tb    = eb_x - {7'b0, lzb};
        exp_d = fdiv ? (ta - tb + bias) : (ta + tb - bias);
    end

    assign prod = 106'(fa_q) * 106'(fb_q);

    // One restoring-division step; remainder stays below 2*fb so 54 bits suffice
    always_comb begin
        qbit    = (rem_q >= {1'b0, fb_q});
        rem_sub = qbit ? (rem_q - {1'b0, fb_q}) : rem_q;
        rem_nxt = rem_sub << 1;
    end

    mul_div_special u_special (
        .fdiv (fdiv_q),
        .fla  (fla_q),
        .flb  (flb_q),
        .nan  (nan_q),
        .flq  (spec_flq)
    );

    // Final result selection; special results force fq and eq to zero
    always_comb begin
        spec_any = spec_flq[FLQ_ZERO] | spec_flq[FLQ_INF] | spec_flq[FLQ_NAN];
        if (spec_any) begin
            res_fq = '0;
            res_eq = '0;
        end else begin
            res_fq = fdiv_q ? {1'b0, quo_q, |rem_q} : {prod_q[105:50], |prod_q[49:0]};
            res_eq = exp_q;
        end
    end

    // Control FSM, operand capture, divider iteration and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            mul_fin_q <= 1'b0;
            fdiv_q    <= 1'b0;
            sign_q    <= 1'b0;
            fa_q      <= '0;
            fb_q      <= '0;
            nan_q     <= '0;
            fla_q     <= '0;
            flb_q     <= '0;
            exp_q     <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            fq_q      <= '0;
            eq_q      <= '0;
            sq_q      <= 1'b0;
            flq_q     <= '0;
        end else begin
            done_q    <= 1'b0;
            mul_fin_q <= 1'b0;
            // Multiply result lands one edge after busy drops, so it may coincide
            // with a new accept; it reads only pre-edge captured state.
            if (mul_fin_q) begin
                fq_q   <= res_fq;
                eq_q   <= res_eq;
                sq_q   <= sign_q;
                flq_q  <= spec_flq;
                done_q <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (start && !busy_q) begin
                        fdiv_q  <= fdiv;
                        sign_q  <= sa ^ sb;
                        fa_q    <= fa;
                        fb_q    <= fb;
                        nan_q   <= nan;
                        fla_q   <= fla;
                        flb_q   <= flb;
                        exp_q   <= exp_d;
                        rem_q   <= {1'b0, fa};
                        quo_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= fdiv ? StDiv : StMul;
                    end
                end
                StMul: begin
                    prod_q    <= prod;
                    mul_fin_q <= 1'b1;
                    busy_q    <= 1'b0;
                    state_q   <= StIdle;
                end
                StDiv: begin
                    rem_q <= rem_nxt;
                    quo_q <= {quo_q[53:0], qbit};
                    cnt_q <= cnt_q + 6'd1;
                    if (cnt_q == 6'(DIV_ITERS - 1)) begin
                        state_q <= StDivOut;
                    end
                end
                StDivOut: begin
                    fq_q    <= res_fq;
                    eq_q    <= res_eq;
                    sq_q    <= sign_q;
                    flq_q   <= spec_flq;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign fq   = fq_q;
    assign eq   = eq_q;
    assign sq   = sq_q;
    assign flq  = flq_q;

endmodule

// File: tb/tb_mul_div.sv
// Self-checking bench for mul_div: vector table plus scoreboard on done.
module tb_mul_div;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset, start, fdiv, db, sa, sb;
    logic [52:0] fa, fb, nan;
    logic [10:0] ea, eb;
    logic [5:0]  lza, lzb;
    logic [3:0]  fla, flb;
    logic        busy, done, sq;
    logic [56:0] fq;
    logic [12:0] eq;
    logic [57:0] flq;

    mul_div dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .fdiv  (fdiv),
        .db    (db),
        .sa    (sa),
        .sb    (sb),
        .fa    (fa),
        .fb    (fb),
        .ea    (ea),
        .eb    (eb),
        .lza   (lza),
        .lzb   (lzb),
        .nan   (nan),
        .fla   (fla),
        .flb   (flb),
        .fq    (fq),
        .eq    (eq),
        .sq    (sq),
        .flq   (flq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic        fdiv, db, sa, sb;
        logic [52:0] fa, fb, nan;
        logic [10:0] ea, eb;
        logic [5:0]  lza, lzb;
        logic [3:0]  fla, flb;
        logic [56:0] x_fq;
        logic [12:0] x_eq;
        logic        x_sq;
        logic [57:0] x_flq;
    } vec_t;

    typedef struct {
        string       name;
        logic [56:0] fq;
        logic [12:0] eq;
        logic        sq;
        logic [57:0] flq;
        int          done_cyc;
    } exp_t;

    localparam logic [52:0] ONE  = 53'h10000000000000;
    localparam logic [52:0] ONE5 = 53'h18000000000000;

    exp_t sbq[$];
    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input string name, input logic fd, input logic d,
                                input logic s_a, input logic s_b,
                                input logic [52:0] f_a, input logic [52:0] f_b,
                                input logic [10:0] e_a, input logic [10:0] e_b,
                                input logic [5:0] l_a, input logic [5:0] l_b,
                                input logic [3:0] fl_a, input logic [3:0] fl_b,
                                input logic [52:0] n);
        vec_t v;
        v.name = name; v.fdiv = fd; v.db = d; v.sa = s_a; v.sb = s_b;
        v.fa = f_a; v.fb = f_b; v.ea = e_a; v.eb = e_b; v.lza = l_a; v.lzb = l_b;
        v.fla = fl_a; v.flb = fl_b; v.nan = n;
        v.x_fq = '0; v.x_eq = '0; v.x_sq = 1'b0; v.x_flq = '0;
        return v;
    endfunction

    function automatic vec_t hand(input vec_t v, input logic [56:0] f, input logic [12:0] e,
                                  input logic s, input logic [57:0] fl);
        v.x_fq = f; v.x_eq = e; v.x_sq = s; v.x_flq = fl;
        return v;
    endfunction

    // Reference model: wide integer product/quotient and a flag case table
    function automatic vec_t model(input vec_t v);
        int bias, xa, xb, e;
        logic [105:0] p;
        logic [107:0] num, q, r;
        logic a_n, b_n, a_z, b_z, a_i, b_i;
        logic [4:0]  f5;
        logic [52:0] s;
        bias = v.db ? 1023 : 127;
        xa = (v.db ? int'(v.ea) : int'(v.ea[7:0])) - int'(v.lza);
        xb = (v.db ? int'(v.eb) : int'(v.eb[7:0])) - int'(v.lzb);
        e  = v.fdiv ? (xa - xb + bias) : (xa + xb - bias);
        v.x_eq = 13'(e);
        v.x_fq = '0;
        if (!v.fdiv) begin
            p = 106'(v.fa) * 106'(v.fb);
            v.x_fq = {p[105:50], |p[49:0]};
        end else if (v.fb != 0) begin
            num = 108'(v.fa) << 54;
            q = num / 108'(v.fb);
            r = num % 108'(v.fb);
            v.x_fq = {1'b0, q[54:0], r != 0};
        end
        v.x_sq = v.sa ^ v.sb;
        a_n = v.fla[1] | v.fla[0]; b_n = v.flb[1] | v.flb[0];
        a_z = v.fla[3]; b_z = v.flb[3]; a_i = v.fla[2]; b_i = v.flb[2];
        f5 = '0; s = '0;
        if (a_n || b_n) begin
            f5 = 5'b00100;
            if (v.fla[0] || v.flb[0]) f5[1] = 1'b1;
            s = v.nan;
        end else if (v.fdiv ? ((a_z && b_z) || (a_i && b_i)) : ((a_z && b_i) || (a_i && b_z))) begin
            f5 = 5'b00110;
            s = QNAN_DEF;
        end else if (v.fdiv ? (a_i || b_z) : (a_i || b_i)) begin
            f5 = 5'b01000;
            if (v.fdiv && b_z && !a_i) f5[0] = 1'b1;
        end else if (a_z || b_z || (v.fdiv && b_i)) begin
            f5 = 5'b10000;
        end
        if (f5[4:2] != 3'b000) begin
            v.x_fq = '0;
            v.x_eq = '0;
        end
        v.x_flq = {f5, s};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        fdiv = v.fdiv; db = v.db; sa = v.sa; sb = v.sb; fa = v.fa; fb = v.fb;
        ea = v.ea; eb = v.eb; lza = v.lza; lzb = v.lzb; nan = v.nan; fla = v.fla; flb = v.flb;
    endtask

    // Issue one operation; pushes its expectation and returns the accept edge number
    task automatic do_op(input vec_t v, output int acc);
        exp_t e;
        int   k;
        @(negedge clk);
        drive(v);
        start = 1'b1;
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (busy) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_accept: got busy stuck at 1, expected accept within 200 cycles", v.name);
            start = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc + 1;
        e.name = v.name; e.fq = v.x_fq; e.eq = v.x_eq; e.sq = v.x_sq; e.flq = v.x_flq;
        e.done_cyc = acc + (v.fdiv ? 56 : 2);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (sbq.size() != 0 && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        if (sbq.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_idle: got %0d results outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding expectation
    always begin : mon
        exp_t e;
        @(posedge clk);
        #1;
        if (done === 1'b1) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at edge %0d, expected done=0", cyc);
            end else begin
                e = sbq.pop_front();
                chk({e.name, "_latency"}, 64'(cyc), 64'(e.done_cyc));
                chk({e.name, "_fq"}, 64'(fq), 64'(e.fq));
                chk({e.name, "_eq"}, 64'(eq), 64'(e.eq));
                chk({e.name, "_sq"}, 64'(sq), 64'(e.sq));
                chk({e.name, "_flq"}, 64'(flq), 64'(e.flq));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1, a2, a3, a4;
        vec_t v;
        reset = 1'b1; start = 1'b0;
        drive(mk("idle", 0, 1, 0, 0, '0, '0, '0, '0, '0, '0, '0, '0, '0));

        tbl.push_back(hand(mk("mul_1p5x1p5", 0, 1, 0, 0, ONE5, ONE5, 1023, 1023, 0, 0, 0, 0, 0),
                           57'h120000000000000, 13'd1023, 0, '0));
        tbl.push_back(hand(mk("div_1_by_1p5", 1, 1, 0, 0, ONE, ONE5, 1023, 1023, 0, 0, 0, 0, 0),
                           57'h055555555555555, 13'd1023, 0, '0));
        tbl.push_back(hand(mk("mul_denorm_exp", 0, 1, 0, 0, ONE, ONE, 1, 1023, 3, 0, 0, 0, 0),
                           57'h080000000000000, 13'h1FFE, 0, '0));
        tbl.push_back(hand(mk("mul_single", 0, 0, 0, 0, ONE5, ONE5, 130, 127, 0, 0, 0, 0, 0),
                           57'h120000000000000, 13'd130, 0, '0));
        tbl.push_back(hand(mk("mul_single_denorm", 0, 0, 0, 0, ONE, ONE, 1, 127, 3, 0, 0, 0, 0),
                           57'h080000000000000, 13'h1FFE, 0, '0));
        tbl.push_back(hand(mk("div_5_by_0", 1, 1, 0, 0, 53'h14000000000000, 0, 1025, 0, 0, 0,
                              4'b0000, 4'b1000, 0), '0, '0, 0, {5'b01001, 53'b0}));
        tbl.push_back(hand(mk("div_0_by_0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1000, 4'b1000, 0),
                           '0, '0, 0, {5'b00110, QNAN_DEF}));
        tbl.push_back(hand(mk("mul_snan_x_1", 0, 1, 0, 0, ONE, ONE, 2047, 1023, 0, 0, 4'b0011, 0,
                              53'h1C000000000123), '0, '0, 0, {5'b00110, 53'h1C000000000123}));
        tbl.push_back(hand(mk("mul_sign", 0, 1, 1, 0, ONE5, ONE, 1000, 1030, 0, 0, 0, 0, 0),
                           57'h0C0000000000000, 13'd1007, 1, '0));
        tbl.push_back(model(mk("mul_0_x_inf", 0, 1, 0, 1, 0, 0, 0, 2047, 0, 0, 4'b1000, 4'b0100,
                               53'h1F0F0F0F0F0F0F)));
        tbl.push_back(model(mk("mul_inf_x_fin", 0, 1, 1, 1, 0, ONE5, 2047, 1000, 0, 0, 4'b0100, 0, 0)));
        tbl.push_back(model(mk("mul_zero_x_fin", 0, 1, 1, 0, 0, ONE5, 0, 1000, 0, 0, 4'b1000, 0, 0)));
        tbl.push_back(model(mk("div_inf_by_inf", 1, 1, 0, 0, 0, 0, 2047, 2047, 0, 0, 4'b0100, 4'b0100, 0)));
        tbl.push_back(model(mk("div_fin_by_inf", 1, 1, 0, 1, ONE5, 0, 900, 2047, 0, 0, 0, 4'b0100, 0)));
        tbl.push_back(model(mk("div_inf_by_0", 1, 1, 0, 0, 0, 0, 2047, 0, 0, 0, 4'b0100, 4'b1000, 0)));
        tbl.push_back(model(mk("div_0_by_fin", 1, 1, 0, 0, 0, ONE5, 0, 1000, 0, 0, 4'b1000, 0, 0)));
        tbl.push_back(model(mk("div_qnan", 1, 1, 1, 0, ONE, ONE, 1000, 2047, 0, 0, 0, 4'b0010,
                               53'h1ABCDEF0123456)));
        for (int i = 0; i < 6; i++) begin
            v = mk($sformatf("rand%0d", i), 1'(i % 2), 1'(i < 4), 1'($urandom), 1'($urandom),
                   {1'b1, 52'({$urandom, $urandom})}, {1'b1, 52'({$urandom, $urandom})},
                   11'($urandom_range(1, 254)), 11'($urandom_range(1, 254)),
                   6'($urandom_range(0, 5)), 6'($urandom_range(0, 5)), 0, 0, 0);
            if (v.db) begin
                v.ea = 11'($urandom_range(1, 2046));
                v.eb = 11'($urandom_range(1, 2046));
            end else begin
                v.fa[28:0] = '0;
                v.fb[28:0] = '0;
            end
            tbl.push_back(model(v));
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_fq", 64'(fq), 0);
        chk("rst_eq", 64'(eq), 0);
        chk("rst_sq", 64'(sq), 0);
        chk("rst_flq", 64'(flq), 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (tbl[i]) begin
            do_op(tbl[i], a1);
            wait_idle();
        end
        repeat (5) @(posedge clk);
        #1;
        chk("hold_fq", 64'(fq), 64'(tbl[tbl.size() - 1].x_fq));
        chk("hold_eq", 64'(eq), 64'(tbl[tbl.size() - 1].x_eq));

        // Multiply busy profile: high one cycle after accept
        do_op(tbl[0], a1);
        chk("mul_busy_cycle1", 64'(busy), 1);
        @(posedge clk);
        #1;
        chk("mul_busy_cycle2", 64'(busy), 0);
        wait_idle();

        // Start while busy must be ignored
        do_op(tbl[1], a1);
        chk("div_busy_after_accept", 64'(busy), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            drive(tbl[0]);
            start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Back-to-back accepts right after done / busy release
        do_op(tbl[1], a1);
        do_op(tbl[2], a2);
        chk("b2b_div_then_mul_accept", 64'(a2), 64'(a1 + 57));
        do_op(tbl[0], a3);
        do_op(tbl[8], a4);
        chk("b2b_mul_then_mul_accept", 64'(a4), 64'(a3 + 2));
        wait_idle();

        // Reset during divide iteration 20: abort, no done, outputs cleared
        do_op(tbl[1], a1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_fq", 64'(fq), 0);
        chk("abort_eq", 64'(eq), 0);
        chk("abort_sq", 64'(sq), 0);
        chk("abort_flq", 64'(flq), 0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (70) @(posedge clk);
        #1;
        chk("abort_busy_after", 64'(busy), 0);
        chk("abort_fq_after", 64'(fq), 0);

        // Core still usable after abort
        do_op(tbl[1], a1);
        wait_idle();
        chk("scoreboard_empty", 64'(sbq.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
